// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op encodings (common
// with the control-signal generator), FSM state encoding and lane geometry.
package lsu_pkg;

  // MemOP width/sign encodings from the decoder
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Data path geometry
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OFF_W  = 2;   // byte offset within a word
  localparam int unsigned STRB_W = 4;   // byte strobes per word
  localparam int unsigned RD_W   = 5;   // register tag width

  // Base strobe patterns before shifting into the addressed lane
  localparam logic [STRB_W-1:0] STRB_BYTE = 4'b0001;
  localparam logic [STRB_W-1:0] STRB_HALF = 4'b0011;
  localparam logic [STRB_W-1:0] STRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: request legality/alignment check,
// store data replication and strobes, load data shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              req_memrd,
  input  logic              req_memwr,
  input  logic [2:0]        req_memop,
  output logic              req_err,
  output logic              req_bus,
  output logic [XLEN-1:0]   st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic [2:0]        ld_memop,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [OFF_W-1:0] off;
  logic             is_half;
  logic             is_word;
  logic             ld_legal;
  logic             st_legal;
  logic             misalign;
  logic [XLEN-1:0]  shifted;

  // Classify the incoming request and build store lanes
  always_comb begin
    off      = req_addr[OFF_W-1:0];
    is_half  = (req_memop == MEMOP_H) || (req_memop == MEMOP_HU);
    is_word  = (req_memop == MEMOP_W);
    ld_legal = (req_memop == MEMOP_B)  || (req_memop == MEMOP_H) ||
               (req_memop == MEMOP_W)  || (req_memop == MEMOP_BU) ||
               (req_memop == MEMOP_HU);
    st_legal = (req_memop == MEMOP_B)  || (req_memop == MEMOP_H) ||
               (req_memop == MEMOP_W);
    misalign = (is_half && off[0]) || (is_word && (off != '0));

    req_err  = (req_memrd && req_memwr) ||
               (req_memrd && !ld_legal) ||
               (req_memwr && !st_legal) ||
               ((req_memrd || req_memwr) && misalign);
    req_bus  = (req_memrd || req_memwr) && !req_err;

    st_wdata = req_wdata;
    st_wstrb = '0;
    if (req_memwr) begin
      case (req_memop)
        MEMOP_B: begin
          st_wdata = {4{req_wdata[7:0]}};
          st_wstrb = STRB_BYTE << off;
        end
        MEMOP_H: begin
          st_wdata = {2{req_wdata[15:0]}};
          st_wstrb = STRB_HALF << off;
        end
        MEMOP_W: begin
          st_wdata = req_wdata;
          st_wstrb = STRB_WORD;
        end
        default: begin
          st_wdata = req_wdata;
          st_wstrb = '0;
        end
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0 and extend it
  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_memop)
      MEMOP_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_BU: ld_data = {24'd0, shifted[7:0]};
      MEMOP_HU: ld_data = {16'd0, shifted[15:0]};
      default:  ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one ALU-addressed request, runs it on the
// req/gnt/rvalid bus with a timeout, and holds the completion for writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_memwr,
  input  logic              in_memrd,
  input  logic [2:0]        in_memop,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);

  // Last counter value before the abort; the cycle in which the counter
  // holds this value is the TIMEOUT_CYCLES-th cycle spent in REQ+RESP.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        memop_q, memop_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  logic              al_err;
  logic              al_bus;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_ldata;
  logic              timeout_hit;

  lsu_align u_align (
    .req_addr  (in_addr),
    .req_wdata (in_wdata),
    .req_memrd (in_memrd),
    .req_memwr (in_memwr),
    .req_memop (in_memop),
    .req_err   (al_err),
    .req_bus   (al_bus),
    .st_wdata  (al_wdata),
    .st_wstrb  (al_wstrb),
    .ld_off    (off_q),
    .ld_memop  (memop_q),
    .ld_rdata  (mem_rdata),
    .ld_data   (al_ldata)
  );

  // Handshake outputs decode straight from the state so reset drops them at once
  assign in_ready  = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign out_valid = (state_q == ST_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;
  assign out_rd    = rd_q;

  // Next-state, timeout counter and latch updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    memop_d     = memop_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rd_d        = rd_q;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rd_d    = in_rd;
          off_d   = in_addr[OFF_W-1:0];
          memop_d = in_memop;
          rdata_d = '0;
          err_d   = al_err;
          cnt_d   = '0;
          if (al_bus) begin
            we_d    = in_memwr;
            addr_d  = {in_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          err_d   = mem_err;
          rdata_d = (mem_err || we_q) ? '0 : al_ldata;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      memop_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      memop_q <= memop_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written reset and
// stray-response sequences, and random transactions against a reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_memwr, in_memrd;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_memop;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_memwr(in_memwr), .in_memrd(in_memrd), .in_memop(in_memop), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_err(out_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        memrd;
    logic        memwr;
    logic [2:0]  memop;
    int unsigned gnt_dly;
    int unsigned rv_dly;
    int unsigned rdy_dly;
    logic [31:0] rdata;
    logic        merr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
    logic        exp_bus;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
    input logic memrd, input logic memwr, input logic [2:0] memop,
    input int unsigned g, input int unsigned rv, input int unsigned rdy,
    input logic [31:0] rdata, input logic merr,
    input logic e_err, input logic [31:0] e_rdata, input int unsigned e_lat,
    input logic e_bus, input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.memrd = memrd; v.memwr = memwr;
    v.memop = memop; v.gnt_dly = g; v.rv_dly = rv; v.rdy_dly = rdy;
    v.rdata = rdata; v.merr = merr; v.exp_err = e_err; v.exp_rdata = e_rdata;
    v.exp_lat = e_lat; v.exp_bus = e_bus; v.exp_wdata = e_wdata; v.exp_wstrb = e_wstrb;
    return v;
  endfunction

  // Reference model: access size/sign from the op, byte arithmetic for lanes
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned sz;
    bit sgn;
    int unsigned o;
    longint unsigned val;
    r = v;
    r.exp_err = 0; r.exp_rdata = 0; r.exp_bus = 0; r.exp_wdata = 0; r.exp_wstrb = 0;
    r.exp_lat = 1;
    sgn = 0;
    case (v.memop)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: sz = 0;
    endcase
    o = v.addr % 4;
    if (!v.memrd && !v.memwr) return r;
    if ((v.memrd && v.memwr) || sz == 0 || (v.memwr && v.memop[2]) || (v.addr % sz) != 0) begin
      r.exp_err = 1;
      return r;
    end
    r.exp_bus = 1;
    if (v.memwr) begin
      r.exp_wstrb = 4'(((1 << sz) - 1) << o);
      for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = 8'(v.wdata >> (8 * (i % sz)));
    end
    if (v.gnt_dly + v.rv_dly + 2 > TO) begin
      r.exp_lat = 1 + TO;
      r.exp_err = 1;
      return r;
    end
    r.exp_lat = v.gnt_dly + v.rv_dly + 3;
    if (v.merr) begin
      r.exp_err = 1;
      return r;
    end
    if (v.memrd) begin
      val = longint'(v.rdata >> (8 * o));
      if (sz < 4) begin
        val = val & ((64'd1 << (8 * sz)) - 1);
        if (sgn && val >= (64'd1 << (8 * sz - 1))) val = val - (64'd1 << (8 * sz));
      end
      r.exp_rdata = val[31:0];
    end
    return r;
  endfunction

  // Run one request from IDLE through the writeback handshake and check it
  task automatic apply(input vec_t v, input string nm);
    int unsigned cyc, reqn, respn, lat, waitn;
    bit gnt_given, req_seen, stable_ok, hold_ok, busy_ok, done;
    logic [31:0] a0, wd0, r0;
    logic [3:0]  ws0;
    logic        we0, e0;
    logic [4:0]  rd0;
    reqn = 0; respn = 0; lat = 0; waitn = 0;
    gnt_given = 0; req_seen = 0; stable_ok = 1; hold_ok = 1; busy_ok = 1; done = 0;
    a0 = '0; wd0 = '0; r0 = '0; ws0 = '0; we0 = 0; e0 = 0; rd0 = '0;
    chk({nm, ".in_ready_start"}, 32'(in_ready), 32'd1);
    in_valid = 1; in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
    in_memrd = v.memrd; in_memwr = v.memwr; in_memop = v.memop; out_ready = 0;
    @(negedge clk);
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    in_memop = 3'($urandom); in_memrd = 1'($urandom); in_memwr = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 60) begin
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
      out_ready = 0; in_valid = 0;
      if (out_valid) begin
        if (lat == 0) begin
          lat = cyc; r0 = out_rdata; e0 = out_err; rd0 = out_rd;
        end else if (out_rdata !== r0 || out_err !== e0 || out_rd !== rd0) hold_ok = 0;
        if (mem_req || in_ready) hold_ok = 0;
        mem_rvalid = 1'($urandom); mem_err = 1'($urandom);
        in_valid = 1;
        if (waitn >= v.rdy_dly) begin
          out_ready = 1;
          done = 1;
        end
        waitn++;
      end else if (mem_req) begin
        if (in_ready || gnt_given) busy_ok = 0;
        if (!req_seen) begin
          req_seen = 1; a0 = mem_addr; wd0 = mem_wdata; ws0 = mem_wstrb; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== wd0 || mem_wstrb !== ws0 || mem_we !== we0)
          stable_ok = 0;
        mem_rvalid = 1'($urandom); mem_err = 1'($urandom);
        if (reqn == v.gnt_dly) begin
          mem_gnt = 1;
          gnt_given = 1;
        end
        reqn++;
      end else begin
        if (in_ready) busy_ok = 0;
        if (gnt_given && respn == v.rv_dly) begin
          mem_rvalid = 1; mem_rdata = v.rdata; mem_err = v.merr;
        end
        respn++;
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; out_ready = 0; in_valid = 0;
    chk({nm, ".in_ready_after"}, 32'(in_ready), 32'd1);
    chk({nm, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({nm, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, ".err"}, 32'(e0), 32'(v.exp_err));
    chk({nm, ".rdata"}, r0, v.exp_rdata);
    chk({nm, ".rd"}, 32'(rd0), 32'(v.rd));
    chk({nm, ".bus_used"}, 32'(req_seen), 32'(v.exp_bus));
    chk({nm, ".req_stable"}, 32'(stable_ok), 32'd1);
    chk({nm, ".done_hold"}, 32'(hold_ok), 32'd1);
    chk({nm, ".busy_no_ready"}, 32'(busy_ok), 32'd1);
    if (v.exp_bus && req_seen) begin
      chk({nm, ".mem_addr"}, a0, {v.addr[31:2], 2'b00});
      chk({nm, ".mem_we"}, 32'(we0), 32'(v.memwr));
      chk({nm, ".mem_wstrb"}, 32'(ws0), 32'(v.exp_wstrb));
      if (v.memwr) chk({nm, ".mem_wdata"}, wd0, v.exp_wdata);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1; in_valid = 0; in_addr = '0; in_wdata = '0; in_memwr = 0; in_memrd = 0;
    in_memop = '0; in_rd = '0; out_ready = 0; mem_gnt = 0; mem_rvalid = 0;
    mem_rdata = '0; mem_err = 0;
    #3 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.out_rdata", out_rdata, 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.out_rd", 32'(out_rd), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    //          addr          wdata         rd    rd wr op      g  rv rdy rdata         me  err rdata         lat bus wdata         wstrb
    tbl.push_back(mk(32'h80000004, 32'h0,        5'd5,  1, 0, 3'b010, 0, 0, 0, 32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000003, 32'h0,        5'd6,  1, 0, 3'b000, 0, 0, 0, 32'h80FF1234, 0,  0, 32'hFFFFFF80, 3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000003, 32'h0,        5'd7,  1, 0, 3'b100, 0, 0, 0, 32'h80FF1234, 0,  0, 32'h00000080, 3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000002, 32'h0,        5'd8,  1, 0, 3'b101, 0, 0, 0, 32'h80FF1234, 0,  0, 32'h000080FF, 3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000002, 32'h0,        5'd9,  1, 0, 3'b001, 0, 0, 0, 32'h80FF1234, 0,  0, 32'hFFFF80FF, 3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000002, 32'h0000ABCD, 5'd10, 0, 1, 3'b001, 0, 0, 0, 32'h0,        0,  0, 32'h0,        3, 1, 32'hABCDABCD, 4'hC));
    tbl.push_back(mk(32'h80000001, 32'h123456A5, 5'd11, 0, 1, 3'b000, 1, 1, 1, 32'h0,        0,  0, 32'h0,        5, 1, 32'hA5A5A5A5, 4'h2));
    tbl.push_back(mk(32'h80000003, 32'h0000005A, 5'd12, 0, 1, 3'b000, 0, 0, 0, 32'h0,        0,  0, 32'h0,        3, 1, 32'h5A5A5A5A, 4'h8));
    tbl.push_back(mk(32'h80000008, 32'hCAFEF00D, 5'd13, 0, 1, 3'b010, 0, 0, 0, 32'h0,        0,  0, 32'h0,        3, 1, 32'hCAFEF00D, 4'hF));
    tbl.push_back(mk(32'h80000002, 32'h0,        5'd14, 1, 0, 3'b010, 0, 0, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000000, 32'h11111111, 5'd15, 0, 1, 3'b100, 0, 0, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000001, 32'h0,        5'd16, 1, 0, 3'b001, 0, 0, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000004, 32'h0,        5'd17, 1, 0, 3'b011, 0, 0, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000004, 32'h0,        5'd18, 1, 1, 3'b010, 0, 0, 0, 32'h0,        0,  1, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000006, 32'h0,        5'd19, 0, 0, 3'b010, 0, 0, 2, 32'h0,        0,  0, 32'h0,        1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(32'h8000000C, 32'h0,        5'd20, 1, 0, 3'b010, 4, 0, 3, 32'h12345678, 0,  0, 32'h12345678, 7, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000010, 32'h0,        5'd21, 1, 0, 3'b010, 0, 0, 0, 32'hFFFFFFFF, 1,  1, 32'h0,        3, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000014, 32'h0,        5'd22, 1, 0, 3'b010, 0, 99, 0, 32'h0,       0,  1, 32'h0,        9, 1, 32'h0,        4'h0));
    tbl.push_back(mk(32'h80000018, 32'h00000001, 5'd23, 0, 1, 3'b010, 99, 0, 1, 32'h0,       0,  1, 32'h0,        9, 1, 32'h00000001, 4'hF));
    tbl.push_back(mk(32'h8000001C, 32'h0,        5'd24, 1, 0, 3'b010, 3, 3, 0, 32'h0BADF00D, 0,  0, 32'h0BADF00D, 9, 1, 32'h0,        4'h0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Stray response while idle must not create a completion
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA; mem_err = 1;
    @(negedge clk);
    mem_rvalid = 0; mem_err = 0;
    @(negedge clk);
    chk("stray.out_valid", 32'(out_valid), 32'd0);
    chk("stray.in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset while waiting for the response
    in_valid = 1; in_addr = 32'h80000020; in_wdata = '0; in_rd = 5'd7;
    in_memrd = 1; in_memwr = 0; in_memop = MEMOP_W;
    @(negedge clk);
    in_valid = 0;
    chk("midrst.req", 32'(mem_req), 32'd1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    rst = 0;
    #1;
    chk("midrst.mem_req", 32'(mem_req), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h01020304;
    @(negedge clk);
    mem_rvalid = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.out_valid_rel", 32'(out_valid), 32'd0);
    apply(mk(32'h80000024, 32'h0, 5'd3, 1, 0, 3'b010, 0, 0, 0, 32'hFEEDC0DE, 0,
             0, 32'hFEEDC0DE, 3, 1, 32'h0, 4'h0), "after_rst");

    // Random traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 7);
      v.addr = $urandom; v.wdata = $urandom; v.rd = 5'($urandom); v.rdata = $urandom;
      v.memop = 3'($urandom);
      v.memrd = (kind == 1) || (kind >= 2 && kind <= 4);
      v.memwr = (kind == 1) || (kind >= 5);
      v.gnt_dly = $urandom_range(0, 3);
      v.rv_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 3);
      v.merr = ($urandom_range(0, 7) == 0);
      apply(model(v), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the npc core.
- Consumes the ALU result as the effective address, rs2 data as store data, and the decoder's MemWr/MemtoReg/MemOP controls.
- Runs one memory transaction on a req/gnt/rvalid data bus, aligns and extends load data, and returns a completion to writeback.
- Supplies the data-memory path currently missing from the busW mux.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before aborting with error; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
in_valid  in  1  upstream request valid
in_ready  out  1  lsu can accept a request (high only in IDLE)
in_addr  in  32  effective address (ALUout)
in_wdata  in  32  store data (rs2)
in_memwr  in  1  store request
in_memrd  in  1  load request (MemtoReg)
in_memop  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_rd  in  5  destination register tag, passed through
out_valid  out  1  completion valid, held until out_ready
out_ready  in  1  writeback accepts completion
out_rdata  out  32  extended load data; 0 for stores and errors
out_rd  out  5  latched in_rd
out_err  out  1  misaligned, illegal op, bus error or timeout
mem_req  out  1  bus request, held until mem_gnt
mem_gnt  in  1  bus grant
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes (0 for reads)
mem_rvalid  in  1  response/write-ack valid
mem_rdata  in  32  read word
mem_err  in  1  bus error, sampled with mem_rvalid

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE.
- Reset: state=IDLE, counter=0. All registered outputs are 0 (out_valid, out_rdata, out_rd, out_err, mem_*). in_ready=1 once rst deasserts.
- IDLE:
  - Accept on in_valid&in_ready and latch all inputs.
  - Error check: error if both memrd and memwr are set. For loads, error if memop is 011/110/111; for stores, error if memop is not 000/001/010. Misaligned: halfword with addr[0]!=0, word with addr[1:0]!=0.
  - Error → DONE with err=1 and no bus activity.
  - Neither memrd nor memwr → DONE with err=0, rdata=0.
  - Otherwise → REQ.
- REQ:
  - mem_req=1 with mem_we/addr/wdata/wstrb stable until mem_gnt.
  - gnt → RESP.
  - mem_rvalid in REQ is ignored; a response is never earlier than the cycle after gnt.
- RESP:
  - Wait for mem_rvalid. Loads: out_rdata=extract(mem_rdata). Stores: out_rdata=0.
  - out_err=mem_err; when mem_err=1, rdata=0.
  - → DONE.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES (nonzero) with no gnt/rvalid that cycle → DONE with err=1, mem_req dropped.
  - A late rvalid in IDLE/DONE is ignored.
- DONE: out_valid=1, outputs stable; out_valid&out_ready → IDLE. in_ready returns 1 the following cycle; no back-to-back accept in the DONE cycle.
- Latency with immediate gnt and rvalid one cycle after gnt: accept at cycle 0, REQ at 1, RESP at 2, out_valid at 3. Error/no-op path: out_valid at cycle 1.
- Store lanes (o = addr[1:0]):
  - sb: wdata={4{d[7:0]}}, wstrb=4'b0001<<o.
  - sh: wdata={2{d[15:0]}}, wstrb=4'b0011<<o.
  - sw: wdata=d, wstrb=4'hF.
- Load extract: s = mem_rdata >> (8*o). b/h sign-extend s[7:0]/s[15:0]; bu/hu zero-extend; w passes s.
- Reset mid-operation: asynchronous return to IDLE. mem_req and out_valid drop immediately; the outstanding transaction is abandoned.

Decomposition:
- Shared package holds:
  - MEMOP_B/H/W/BU/HU constants (3-bit, shared with CSG).
  - lsu state encoding.
  - Width/alignment helper constants.
- One combinational sub-module, lsu_align: store lane replicate/strobe generation, load shift+extend, misalign/illegal detect.
- The FSM, timeout counter and latches stay in lsu.

Test Plan:
- Load word: addr=0x80000004, lw, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF → out_valid at cycle 3, out_rdata=0xDEADBEEF, err=0, out_rd echoed.
- Byte/half lanes:
  - lb addr=0x80000003, rdata=0x80FF1234 → 0xFFFFFF80.
  - lbu → 0x00000080.
  - lhu addr=0x80000002 → 0x000080FF.
  - sh addr ...2, d=0x0000ABCD → wdata=0xABCDABCD, wstrb=0xC, mem_we=1.
- Misaligned/illegal:
  - lw addr=0x80000002 → out_valid at cycle 1, err=1, mem_req never asserted.
  - Store memop=100 → same error response.
- Handshake stalls: gnt delayed 4 cycles, out_ready low 3 cycles → mem_req/addr stable throughout, out_valid/out_rdata held, in_ready=0 until 1 cycle after out_ready.
- Bus error/timeout:
  - rvalid with mem_err=1 → err=1, rdata=0.
  - No rvalid, TIMEOUT_CYCLES=8 → err=1 after 8 cycles in REQ+RESP; a later stray rvalid is ignored.
- Reset mid-RESP: drive rst=0 while in RESP → mem_req/out_valid 0 immediately. After release, in_ready=1 and a fresh lw completes normally.
